// File: rtl/key_expand_if.sv
// Key-schedule bus: loader key/flag in, round-key read port and status out.
interface key_expand_if;
  logic [128:1] key;
  logic         key_ok_;
  logic [3:0]   rd_idx;
  logic [128:1] rd_key;
  logic         done_;
  logic         busy;

  modport master (output key, key_ok_, rd_idx, input rd_key, done_, busy);
  modport slave  (input key, key_ok_, rd_idx, output rd_key, done_, busy);
endinterface

// File: rtl/key_expand.sv
// AES-128 key schedule: expands the loader key into 11 round keys, one per clock,
// and exposes them through a combinational read port.
module key_expand_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = x;
    bb = y;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  logic [7:0] pw, inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expand #(
  parameter int unsigned NR = 10
) (
  input logic        clk,
  input logic        rst_,
  key_expand_if.slave kif
);
  if (NR != 10) begin : g_nr_check
    $error("key_expand supports only NR=10");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state;
  logic [127:0] store [0:10];
  logic [31:0]  w [0:3];
  logic [3:0]   rnd;
  logic         key_ok_d;
  logic         done_q;
  logic         busy_q;
  logic         start;
  logic [31:0]  rot, sub, temp, n0, n1, n2, n3;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign start = key_ok_d & ~kif.key_ok_;
  assign rot   = {w[3][23:0], w[3][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_expand_sbox u_sbox (.a(rot[8*g +: 8]), .s(sub[8*g +: 8]));
  end

  assign temp = sub ^ {rcon_of(rnd), 24'h0};
  assign n0   = w[0] ^ temp;
  assign n1   = w[1] ^ n0;
  assign n2   = w[2] ^ n1;
  assign n3   = w[3] ^ n2;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      done_q   <= 1'b1;
      busy_q   <= 1'b0;
      rnd      <= '0;
      key_ok_d <= 1'b1;
      for (int unsigned i = 0; i < 11; i++) store[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) w[i] <= '0;
    end else begin
      key_ok_d <= kif.key_ok_;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            store[0] <= kif.key;
            w[0]     <= kif.key[128:97];
            w[1]     <= kif.key[96:65];
            w[2]     <= kif.key[64:33];
            w[3]     <= kif.key[32:1];
            rnd      <= 4'd1;
            busy_q   <= 1'b1;
            done_q   <= 1'b1;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
          // Loader withdrawing the key aborts before this cycle's write.
          if (kif.key_ok_) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            store[rnd] <= {n0, n1, n2, n3};
            w[0]       <= n0;
            w[1]       <= n1;
            w[2]       <= n2;
            w[3]       <= n3;
            if (rnd == 4'(NR)) begin
              busy_q <= 1'b0;
              done_q <= 1'b0;
              state  <= DONE;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    kif.rd_key = '0;
    if (kif.rd_idx <= 4'd10) kif.rd_key = store[kif.rd_idx];
  end

  assign kif.done_ = done_q;
  assign kif.busy  = busy_q;
endmodule

// File: doc/key_expand.md
Name: key_expand

Overview:
- AES-128 key schedule stage directly downstream of the serial key loader.
- Consumes the loader's 128-bit assembled key and its active-low key_ok_ flag.
- Iteratively derives round keys 0..10, one per clock, into an internal 11-entry round-key store.
- The cipher round datapath reads the store through a combinational read port; done_ tells it when the keys are valid.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, other values are illegal.

Ports:
clk  input  1  system clock, rising edge.
rst_  input  1  asynchronous active-low reset.
key  input  128  cipher key from loader; key[128:121] is byte 0, w0 = key[128:97], w3 = key[32:1].
key_ok_  input  1  active-low; low = key is complete and stable.
rd_idx  input  4  round-key select, 0..10.
rd_key  output  128  round key rd_idx, same byte order as key; combinational from the store.
done_  output  1  active-low; low = all 11 round keys valid.
busy  output  1  high while expansion is in progress.

Behaviour:
- Reset (rst_ low, asynchronous):
  - State IDLE; done_=1, busy=0.
  - Store entries cleared to 0; round counter 0; key_ok_d=1.
- key_ok_d is a registered copy of key_ok_. The start event is key_ok_d=1 and key_ok_=0 (falling edge), sampled at a rising clk edge.
- States:
  - IDLE: on start, capture key into entry 0 and load the working words w0..w3; rnd=1; busy=1; done_=1; go to EXPAND.
  - EXPAND: each cycle compute round key rnd from the working words and write it to entry rnd and to the working words.
    - temp = SubWord(RotWord(w3)) xor {rcon[rnd],24'h0}.
    - n0 = w0^temp; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
    - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
    - When rnd==10, write entry 10 and go to DONE.
  - DONE: done_=0, busy=0. Hold the store until a new start event or reset.
- Latency: start sampled at edge N.
  - Entry 0 written at N.
  - Entries 1..10 written at N+1..N+10.
  - done_ falls and busy falls at N+10.
  - 11 cycles from start to done.
- SubWord uses four instances of the shared forward S-box (combinational, byte-wise). The S-box table is outside this block's scope.
- Read port: rd_key = store[rd_idx] for rd_idx 0..10; rd_key = 0 for rd_idx 11..15. It is valid at any time, but contents are only guaranteed when done_=0.
- Boundary cases:
  - key_ok_ rising during EXPAND: abort to IDLE, done_=1, busy=0. Store contents are undefined-but-stable; no further writes.
  - New start event in DONE: done_ returns to 1 at the same edge, and expansion restarts from the new key.
  - key_ok_ held low continuously: no retrigger (edge-based).
  - key_ok_ already low on reset release: key_ok_d resets to 1, so the first edge after reset counts as a start. This is intentional: the loader may finish while rst_ is deasserting.
  - Reset mid-EXPAND: immediate return to reset values.
  - key changing during EXPAND is ignored, since only the start-edge value is used.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ok_ 1->0 -> done_ low exactly 10 edges after the start edge.
  - rd_idx=0 gives 2b7e151628aed2a6abf7158809cf4f3c.
  - rd_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> rd_idx=1 gives 62636363626363636263636362636363; rd_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Pulse key_ok_ high at the 5th EXPAND cycle -> busy=0 and done_=1 next edge; no further store writes; a fresh 1->0 restarts and completes in 11 cycles.
- Assert rst_ low mid-EXPAND -> done_=1, busy=0, and rd_key=0 for all indices, asynchronously (no clk needed).
- In DONE, load a new key and toggle key_ok_ 1->0 -> done_ goes high at the start edge, then low 10 edges later with the new schedule; rd_idx=12 returns 0 throughout.
